tape_fsk_encoder: RTL and testbench
===================================

TAPE_FSK_ENCODER -- requirements
Module: tape_fsk_encoder

Interface
REQ-001 SHALL have parameter HP_ONE, default 4444, giving the half-period of the "1" tone in clk cycles (2400 Hz at 21.33 MHz).
REQ-002 SHALL have parameter HP_ZERO, default 8889, giving the half-period of the "0" tone in clk cycles (1200 Hz).
REQ-003 SHALL have parameter LEADER_CYCLES, default 16000, giving the number of full "1"-tone cycles in a leader.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. All state changes occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port play, input, 1 bit: 1 runs the encoder; 0 pauses it (motor off).
REQ-007 SHALL have port leader_req, input, 1 bit: a one-cycle request to emit a leader tone.
REQ-008 SHALL have port byte_valid, input, 1 bit: byte offered by the upstream fetcher.
REQ-009 SHALL have port byte_data, input, 8 bits: the offered byte.
REQ-010 SHALL have port byte_ready, output, 1 bit: the encoder accepts a byte this cycle.
REQ-011 SHALL have port data, output, 1 bit: the FSK tape waveform, which feeds the console tape input.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement the states IDLE, LEADER, START, DATA and STOP.
REQ-014 SHALL register byte_data when byte_valid and byte_ready are both high, and then move IDLE->START.
REQ-015 SHALL drive byte_ready = (state==IDLE) & play & ~leader_req & ~reset, combinationally.
REQ-016 SHALL move IDLE->LEADER when leader_req & play is seen in IDLE; leader_req takes priority over a simultaneous byte_valid.
REQ-017 SHALL ignore leader_req outside IDLE.
REQ-018 SHALL encode each bit as follows: bit "0" = one full cycle with half-period HP_ZERO; bit "1" = two full cycles with half-period HP_ONE.
REQ-019 SHALL shape each cycle as data=1 for the first half-period, then data=0 for the second.
REQ-020 SHALL start every bit cell on the edge after the preceding cell ends, with no gap between cells.
REQ-021 SHALL make data go high on the edge after the accept/leader edge; that is, first-edge latency is 1 clk.
REQ-022 SHALL frame each byte as 1 start bit "0", then 8 data bits LSB first, then 2 stop bits "1".
REQ-023 SHALL use a bit counter 0..7 in DATA and 0..1 in STOP.
REQ-024 SHALL emit LEADER_CYCLES full "1"-tone cycles in LEADER, then return to IDLE.
REQ-025 SHALL return from STOP to IDLE on the final edge of stop bit 2; byte_ready may be high on the next cycle, so back-to-back bytes have no idle gap.
REQ-026 SHALL implement the half-period counter so that it loads HP-1 and decrements; at 0 it toggles the half, and after the second half it advances the cycle/bit count.
REQ-027 SHALL size the counter widths as $clog2 of the largest parameter; no wrap-around may occur within legal parameter values.
REQ-028 SHALL, when play=0, freeze all counters, the state and the shift register, hold data at its current level, and hold byte_ready low.
REQ-029 SHALL, when play later returns to 1, resume exactly where it was paused.
REQ-030 SHALL hold data=0 in IDLE.

Reset
REQ-031 SHALL, while reset is high at a clk edge, force state=IDLE, data=0, busy=0, all counters=0 and the shift register=0.
REQ-032 SHALL hold byte_ready=0 throughout reset.
REQ-033 SHALL abandon any byte or leader in progress when reset is asserted mid-operation; the byte is not resumed.
REQ-034 SHALL make byte_ready high on the first cycle after reset deasserts, provided play=1 and leader_req=0.

Verification (HP_ONE=2, HP_ZERO=4, LEADER_CYCLES=3)
REQ-035 SHALL cover this scenario: leader_req pulse in IDLE with play=1 -> data reads 1,1,0,0 repeated 3 times (12 clk); busy is high for 12 clk; then IDLE with data=0.
REQ-036 SHALL cover this scenario: byte 0x00 accepted -> 9 zero cells (1111 0000, 8 clk each), then 2 one cells (1100 1100, 8 clk each). Total 88 clk; byte_ready is low throughout and high on clk 89.
REQ-037 SHALL cover this scenario: byte 0x01 -> the first data cell after the start cell is the "1" pattern 11001100, and the next 7 cells are "0".
REQ-038 SHALL cover this scenario: byte_valid and leader_req high in the same IDLE cycle -> leader is emitted, the byte is not accepted (byte_ready=0), and the byte is accepted after the leader ends.
REQ-039 SHALL cover this scenario: play dropped for 10 clk mid-DATA -> data and the counters are frozen; the total frame length grows by exactly 10 clk and the bit sequence is unchanged.
REQ-040 SHALL cover this scenario: reset asserted for 1 clk mid-STOP -> data=0 and busy=0 on the next cycle, and byte_ready=1 on the cycle after reset deasserts.

Source files
------------

// File: rtl/tape_fsk_encoder.sv
// tape_fsk_encoder
// Serialises bytes into a Kansas-City-style FSK waveform for a cassette
// input. A "0" cell is one full cycle of the low tone (half-period HP_ZERO).
// A "1" cell is two full cycles of the high tone (half-period HP_ONE).
// Each cycle is high for its first half and low for its second half.
// Every byte is framed as: one start "0", eight data bits LSB first, then
// two stop "1"s. A leader is LEADER_CYCLES cycles of the high tone.
//
// Ports
//   clk        : single clock; all state changes happen on its rising edge
//   reset      : synchronous, active-high reset
//   play       : 1 = run; 0 = pause (everything frozen, data held)
//   leader_req : one-cycle request for a leader; only honoured in IDLE
//   byte_valid : upstream is offering byte_data
//   byte_data  : byte to be encoded
//   byte_ready : byte is accepted this cycle (combinational)
//   data       : FSK tape waveform
//   busy       : high in any state other than IDLE
`timescale 1ns/1ps
module tape_fsk_encoder #(
    parameter int HP_ONE        = 4444,
    parameter int HP_ZERO       = 8889,
    parameter int LEADER_CYCLES = 16000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play,
    input  logic       leader_req,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       data,
    output logic       busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEADER = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Counters only ever hold values up to (parameter - 1).
    localparam int MAXP = (HP_ONE > HP_ZERO)
                        ? ((HP_ONE  > LEADER_CYCLES) ? HP_ONE  : LEADER_CYCLES)
                        : ((HP_ZERO > LEADER_CYCLES) ? HP_ZERO : LEADER_CYCLES);
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [CW-1:0] HP1_LD  = CW'(HP_ONE - 1);
    localparam logic [CW-1:0] HP0_LD  = CW'(HP_ZERO - 1);
    localparam logic [CW-1:0] LC_LAST = CW'(LEADER_CYCLES - 1);

    logic [2:0]    state;
    logic [CW-1:0] hp_cnt;    // remaining clocks in the current half-period
    logic [CW-1:0] cyc_cnt;   // full tone cycles completed within the cell
    logic          half;      // 0 = high half, 1 = low half
    logic [2:0]    bit_cnt;   // 0..7 in DATA, 0..1 in STOP
    logic [7:0]    shreg;     // data bits still to send, LSB is current

    logic          cur_one;   // value of the bit cell being emitted
    logic          nxt_one;   // value of the cell that follows this one
    logic          last_cyc;  // the tone cycle in progress ends the cell
    logic [CW-1:0] cur_ld;
    logic [CW-1:0] nxt_ld;

    assign busy       = (state != S_IDLE);
    assign byte_ready = (state == S_IDLE) & play & ~leader_req & ~reset;

    always_comb begin
        cur_one = 1'b1;
        nxt_one = 1'b1;
        case (state)
            S_START: begin
                cur_one = 1'b0;
                nxt_one = shreg[0];
            end
            S_DATA: begin
                cur_one = shreg[0];
                // After bit 7 comes the first stop bit.
                nxt_one = (bit_cnt == 3'd7) ? 1'b1 : shreg[1];
            end
            default: ;
        endcase

        if (state == S_LEADER)
            last_cyc = (cyc_cnt == LC_LAST);
        else if (cur_one)
            last_cyc = (cyc_cnt == CW'(1));
        else
            last_cyc = 1'b1;

        cur_ld = cur_one ? HP1_LD : HP0_LD;
        nxt_ld = nxt_one ? HP1_LD : HP0_LD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            data    <= 1'b0;
            hp_cnt  <= '0;
            cyc_cnt <= '0;
            half    <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (play) begin
            case (state)
                S_IDLE: begin
                    data <= 1'b0;
                    // The first cell begins on the accepting edge, so the
                    // waveform goes high one clock after the request.
                    if (leader_req) begin
                        state   <= S_LEADER;
                        data    <= 1'b1;
                        half    <= 1'b0;
                        hp_cnt  <= HP1_LD;
                        cyc_cnt <= '0;
                    end else if (byte_valid && byte_ready) begin
                        shreg   <= byte_data;
                        state   <= S_START;
                        data    <= 1'b1;
                        half    <= 1'b0;
                        hp_cnt  <= HP0_LD;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                default: begin
                    if (hp_cnt != '0) begin
                        hp_cnt <= hp_cnt - 1'b1;
                    end else if (!half) begin
                        half   <= 1'b1;
                        data   <= 1'b0;
                        hp_cnt <= cur_ld;
                    end else if (!last_cyc) begin
                        // Another tone cycle within the same cell.
                        cyc_cnt <= cyc_cnt + 1'b1;
                        half    <= 1'b0;
                        data    <= 1'b1;
                        hp_cnt  <= cur_ld;
                    end else begin
                        // Cell done: start the next one on this same edge.
                        cyc_cnt <= '0;
                        half    <= 1'b0;
                        data    <= 1'b1;
                        hp_cnt  <= nxt_ld;
                        case (state)
                            S_LEADER: begin
                                state  <= S_IDLE;
                                data   <= 1'b0;
                                hp_cnt <= '0;
                            end
                            S_START: begin
                                state   <= S_DATA;
                                bit_cnt <= '0;
                            end
                            S_DATA: begin
                                shreg <= {1'b0, shreg[7:1]};
                                if (bit_cnt == 3'd7) begin
                                    state   <= S_STOP;
                                    bit_cnt <= '0;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            S_STOP: begin
                                if (bit_cnt == 3'd1) begin
                                    state   <= S_IDLE;
                                    data    <= 1'b0;
                                    hp_cnt  <= '0;
                                    bit_cnt <= '0;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            default: begin
                                state  <= S_IDLE;
                                data   <= 1'b0;
                                hp_cnt <= '0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tape_fsk_encoder.sv
// tb_tape_fsk_encoder
// Directed bench for tape_fsk_encoder with small tone parameters. Expected
// per-clock (data, busy, byte_ready) triples are queued when stimulus is
// driven and compared by a monitor after every clock edge that had play=1.
// While play=0 the monitor checks that data and busy are held.
`timescale 1ns/1ps
module tb_tape_fsk_encoder;

    localparam int HP_ONE        = 2;
    localparam int HP_ZERO       = 4;
    localparam int LEADER_CYCLES = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play = 1'b1;
    logic       leader_req = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_ready;
    logic       data;
    logic       busy;

    typedef struct packed {
        logic d;
        logic b;
        logic r;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;

    tape_fsk_encoder #(
        .HP_ONE       (HP_ONE),
        .HP_ZERO      (HP_ZERO),
        .LEADER_CYCLES(LEADER_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .leader_req (leader_req),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .data       (data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_e(input logic d, input logic b, input logic r);
        exp_t e;
        e.d = d; e.b = b; e.r = r;
        q.push_back(e);
    endtask

    task automatic push_cycle(input int hp);
        for (int i = 0; i < hp; i++) push_e(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < hp; i++) push_e(1'b0, 1'b1, 1'b0);
    endtask

    task automatic push_bit(input logic b);
        if (b) begin
            push_cycle(HP_ONE);
            push_cycle(HP_ONE);
        end else begin
            push_cycle(HP_ZERO);
        end
    endtask

    // Whole frame followed by the idle cycle where byte_ready returns.
    task automatic push_frame(input logic [7:0] v);
        push_bit(1'b0);
        for (int i = 0; i < 8; i++) push_bit(v[i]);
        push_bit(1'b1);
        push_bit(1'b1);
        push_e(1'b0, 1'b0, 1'b1);
    endtask

    task automatic push_leader();
        for (int i = 0; i < LEADER_CYCLES; i++) push_cycle(HP_ONE);
        push_e(1'b0, 1'b0, 1'b1);
    endtask

    // Bounded wait until the scoreboard has drained to n entries.
    task automatic wait_q(input int n, input string tag);
        int k;
        k = 0;
        while (q.size() > n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (q.size() > n) chk({tag, "_timeout"}, q.size(), n);
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = v;
        push_frame(v);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Monitor: outputs after an edge with play=1 advance the scoreboard;
    // after an edge with play=0 they must not have moved.
    always @(posedge clk) begin
        logic p, pd, pb;
        exp_t e;
        p  = play;
        pd = data;
        pb = busy;
        #1;
        if (busy) busy_cnt++;
        if (p) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("data", data, e.d);
                chk("busy", busy, e.b);
                chk("byte_ready", byte_ready, e.r);
            end
        end else begin
            chk("pause_data_hold", data, pd);
            chk("pause_busy_hold", busy, pb);
            chk("pause_ready_low", byte_ready, 1'b0);
        end
    end

    initial begin
        int b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_data", data, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", byte_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", byte_ready, 1'b1);

        // Leader: 1100 x3, busy 12 clk, then idle
        @(negedge clk);
        leader_req = 1'b1;
        push_leader();
        @(negedge clk);
        leader_req = 1'b0;
        wait_q(0, "leader");
        repeat (2) @(negedge clk);

        // Byte 0x00: 88 clk frame
        b0 = busy_cnt;
        send_byte(8'h00);
        wait_q(0, "byte00");
        chk("byte00_len", busy_cnt - b0, 88);
        repeat (2) @(negedge clk);

        // Byte 0x01
        send_byte(8'h01);
        wait_q(0, "byte01");

        // Leader and byte in the same cycle: leader wins, byte follows
        @(negedge clk);
        leader_req = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hC3;
        #1;
        chk("ready_low_with_leader", byte_ready, 1'b0);
        push_leader();
        push_frame(8'hC3);
        @(negedge clk);
        leader_req = 1'b0;
        wait_q(88, "leader_then_byte");
        @(negedge clk);
        byte_valid = 1'b0;
        wait_q(0, "byteC3");
        repeat (2) @(negedge clk);

        // Pause 10 clk mid-DATA
        b0 = busy_cnt;
        send_byte(8'h5A);
        wait_q(50, "pause_pre");
        @(negedge clk);
        play = 1'b0;
        repeat (10) @(negedge clk);
        play = 1'b1;
        wait_q(0, "pause_post");
        chk("pause_len", busy_cnt - b0, 98);
        repeat (2) @(negedge clk);

        // Reset for 1 clk in the second stop bit
        send_byte(8'h3C);
        wait_q(6, "stop_reach");
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        push_e(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_mid_rst", byte_ready, 1'b1);
        chk("busy_after_mid_rst", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("not_resumed_busy", busy, 1'b0);
        chk("not_resumed_data", data, 1'b0);

        // Encoder is usable again after the abort
        send_byte(8'hA5);
        wait_q(0, "byteA5");
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
